// File: rtl/color_map_if.sv
// Stream interface for color_map_pipe: sample input side and RGB output side.
// master = the bench/upstream+downstream view, slave = the mapper's view.
interface color_map_if #(
  parameter int IN_W = 12
);
  logic [IN_W-1:0] in_val;
  logic            in_sof;
  logic            in_valid;
  logic            in_ready;
  logic [23:0]     rgb;
  logic            out_sof;
  logic            out_valid;
  logic            out_ready;

  modport master (
    output in_val, in_sof, in_valid, out_ready,
    input  in_ready, rgb, out_sof, out_valid
  );

  modport slave (
    input  in_val, in_sof, in_valid, out_ready,
    output in_ready, rgb, out_sof, out_valid
  );
endinterface

// File: rtl/color_map_pipe.sv
// color_map_pipe: 3-stage log-magnitude to 24-bit RGB mapper.
//   S1: frame config latch, floor subtract, gain, saturate.
//   S2: index extraction and synchronous palette RAM read (read-first).
//   S3: palette-mode mux into the registered rgb output.
// All stages advance together on en = !out_valid | out_ready.
// Optional feature macro: COLOR_MAP_CLIP_FLAG_EN adds out_clip and clip_count.
module color_map_pipe #(
  parameter int IN_W      = 12,
  parameter int LUT_AW    = 8,
  parameter int GAIN_FRAC = 4
) (
  input  logic              clk,
  input  logic              rst,
  color_map_if.slave        strm,
  input  logic [1:0]        cfg_mode,
  input  logic [IN_W-1:0]   cfg_floor,
  input  logic [7:0]        cfg_gain,
  input  logic              lut_we,
  input  logic [LUT_AW-1:0] lut_addr,
  input  logic [23:0]       lut_wdata
`ifdef COLOR_MAP_CLIP_FLAG_EN
  ,
  output logic              out_clip,
  output logic [15:0]       clip_count
`endif
);

  localparam int P_W              = IN_W + 8;
  // Only the top bits of the amplitude are ever used downstream.
  localparam int TOP_W            = (LUT_AW > 8) ? LUT_AW : 8;
  localparam logic [7:0] GAIN_ONE = 8'(1 << GAIN_FRAC);

  // Heat palette: black -> red -> yellow -> white in three 85-step ramps.
  function automatic logic [23:0] heat_rgb(input logic [7:0] i);
    logic [7:0] ramp;
    if (i < 8'd85) begin
      ramp     = i * 8'd3;
      heat_rgb = {ramp, 8'h00, 8'h00};
    end else if (i < 8'd170) begin
      ramp     = (i - 8'd85) * 8'd3;
      heat_rgb = {8'hFF, ramp, 8'h00};
    end else begin
      ramp     = (i - 8'd170) * 8'd3;
      heat_rgb = {8'hFF, 8'hFF, ramp};
    end
  endfunction

  logic en_s;
  logic acc_s;

  logic [1:0]      act_mode_r;
  logic [IN_W-1:0] act_floor_r;
  logic [7:0]      act_gain_r;

  logic [1:0]       eff_mode_s;
  logic [IN_W-1:0]  eff_floor_s;
  logic [7:0]       eff_gain_s;
  logic [IN_W-1:0]  diff_s;
  logic [P_W-1:0]   prod_s;
  logic [P_W-1:0]   shft_s;
  logic [IN_W-1:0]  amp_s;
  logic [TOP_W-1:0] amp_top_s;
  logic             sat_s;

  logic             s1_valid_r;
  logic             s1_sof_r;
  logic [1:0]       s1_mode_r;
  logic [TOP_W-1:0] s1_top_r;

  logic              s2_valid_r;
  logic              s2_sof_r;
  logic [1:0]        s2_mode_r;
  logic [7:0]        s2_idx_r;
  logic [LUT_AW-1:0] laddr_s;
  logic [23:0]       pal_q_r;
  logic [23:0]       pal_mem [0:(1 << LUT_AW) - 1];

  logic [23:0] mux_s;
  logic [23:0] rgb_r;
  logic        out_sof_r;
  logic        out_valid_r;

  assign en_s          = !out_valid_r || strm.out_ready;
  assign acc_s         = strm.in_valid && en_s;
  assign strm.in_ready = en_s;
  assign strm.rgb      = rgb_r;
  assign strm.out_sof  = out_sof_r;
  assign strm.out_valid = out_valid_r;

  // S1 combinational datapath: SOF beats use the incoming config directly.
  always_comb begin
    if (strm.in_sof) begin
      eff_mode_s  = cfg_mode;
      eff_floor_s = cfg_floor;
      eff_gain_s  = cfg_gain;
    end else begin
      eff_mode_s  = act_mode_r;
      eff_floor_s = act_floor_r;
      eff_gain_s  = act_gain_r;
    end
    if (strm.in_val > eff_floor_s) begin
      diff_s = strm.in_val - eff_floor_s;
    end else begin
      diff_s = {IN_W{1'b0}};
    end
    prod_s = P_W'(diff_s) * P_W'(eff_gain_s);
    shft_s = prod_s >> GAIN_FRAC;
    if (|shft_s[P_W-1:IN_W]) begin
      sat_s = 1'b1;
      amp_s = {IN_W{1'b1}};
    end else begin
      sat_s = 1'b0;
      amp_s = shft_s[IN_W-1:0];
    end
    amp_top_s = TOP_W'(amp_s >> (IN_W - TOP_W));
  end

  // S1 registers: active frame config and the scaled amplitude.
  always_ff @(posedge clk) begin
    if (!rst) begin
      act_mode_r  <= 2'd0;
      act_floor_r <= {IN_W{1'b0}};
      act_gain_r  <= GAIN_ONE;
      s1_valid_r  <= 1'b0;
      s1_sof_r    <= 1'b0;
      s1_mode_r   <= 2'd0;
      s1_top_r    <= {TOP_W{1'b0}};
    end else begin
      if (acc_s && strm.in_sof) begin
        act_mode_r  <= cfg_mode;
        act_floor_r <= cfg_floor;
        act_gain_r  <= cfg_gain;
      end
      if (en_s) begin
        s1_valid_r <= strm.in_valid;
        s1_sof_r   <= strm.in_sof;
        s1_mode_r  <= eff_mode_s;
        s1_top_r   <= amp_top_s;
      end
    end
  end

  assign laddr_s = s1_top_r[TOP_W-1 -: LUT_AW];

  // Palette RAM: writes never stall; the stalled read port returns the pre-write entry.
  always_ff @(posedge clk) begin
    if (lut_we) begin
      pal_mem[lut_addr] <= lut_wdata;
    end
    if (en_s) begin
      pal_q_r <= pal_mem[laddr_s];
    end
  end

  // S2 registers: 8-bit palette index and per-sample mode.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s2_valid_r <= 1'b0;
      s2_sof_r   <= 1'b0;
      s2_mode_r  <= 2'd0;
      s2_idx_r   <= 8'd0;
    end else if (en_s) begin
      s2_valid_r <= s1_valid_r;
      s2_sof_r   <= s1_sof_r;
      s2_mode_r  <= s1_mode_r;
      s2_idx_r   <= s1_top_r[TOP_W-1 -: 8];
    end
  end

  // S3 mode mux: select the colour for the sample's own mode.
  always_comb begin
    case (s2_mode_r)
      2'd0:    mux_s = {s2_idx_r, s2_idx_r, s2_idx_r};
      2'd1:    mux_s = heat_rgb(s2_idx_r);
      2'd2:    mux_s = pal_q_r;
      2'd3:    mux_s = {~s2_idx_r, ~s2_idx_r, ~s2_idx_r};
      default: mux_s = 24'd0;
    endcase
  end

  // S3 output registers, held while downstream stalls.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_r <= 1'b0;
      out_sof_r   <= 1'b0;
      rgb_r       <= 24'd0;
    end else if (en_s) begin
      out_valid_r <= s2_valid_r;
      out_sof_r   <= s2_sof_r;
      rgb_r       <= mux_s;
    end
  end

`ifdef COLOR_MAP_CLIP_FLAG_EN
  logic        s1_clip_r;
  logic        s2_clip_r;
  logic        out_clip_r;
  logic [15:0] clip_cnt_r;

  assign out_clip   = out_clip_r;
  assign clip_count = clip_cnt_r;

  // Saturation flag rides alongside the sample through all three stages.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_clip_r  <= 1'b0;
      s2_clip_r  <= 1'b0;
      out_clip_r <= 1'b0;
    end else if (en_s) begin
      s1_clip_r  <= sat_s;
      s2_clip_r  <= s1_clip_r;
      out_clip_r <= s2_clip_r;
    end
  end

  // Clipped-transfer counter: restarts at each accepted SOF, sticks at 0xFFFF.
  always_ff @(posedge clk) begin
    if (!rst) begin
      clip_cnt_r <= 16'd0;
    end else if (acc_s && strm.in_sof) begin
      clip_cnt_r <= 16'd0;
    end else if (out_valid_r && strm.out_ready && out_clip_r && (clip_cnt_r != 16'hFFFF)) begin
      clip_cnt_r <= clip_cnt_r + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_color_map_pipe.sv
// Self-checking bench for color_map_pipe: directed cases plus randomized
// traffic scored against a behavioural colour-mapping model.
module tb_color_map_pipe;
  localparam int IN_W      = 12;
  localparam int LUT_AW    = 8;
  localparam int GAIN_FRAC = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  color_map_if #(.IN_W(IN_W)) bus ();

  logic [1:0]        cfg_mode;
  logic [IN_W-1:0]   cfg_floor;
  logic [7:0]        cfg_gain;
  logic              lut_we;
  logic [LUT_AW-1:0] lut_addr;
  logic [23:0]       lut_wdata;

  color_map_pipe #(.IN_W(IN_W), .LUT_AW(LUT_AW), .GAIN_FRAC(GAIN_FRAC)) dut (
    .clk       (clk),
    .rst       (rst),
    .strm      (bus),
    .cfg_mode  (cfg_mode),
    .cfg_floor (cfg_floor),
    .cfg_gain  (cfg_gain),
    .lut_we    (lut_we),
    .lut_addr  (lut_addr),
    .lut_wdata (lut_wdata)
  );

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  bit chk_lat = 1'b0;

  // reference model state
  int          m_mode, m_floor, m_gain;
  logic [23:0] pal_m [0:(1 << LUT_AW) - 1];
  logic [23:0] q_rgb [$];
  bit          q_sof [$];
  int          q_cyc [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Colour for one sample straight from the mapping rules.
  function automatic logic [23:0] ref_rgb(input int v, input int mode, input int fl, input int gn);
    int d, a, i, la, r, g, b;
    d = v - fl;
    if (d < 0) d = 0;
    a = (d * gn) / (1 << GAIN_FRAC);
    if (a > (1 << IN_W) - 1) a = (1 << IN_W) - 1;
    i  = a / (1 << (IN_W - 8));
    la = a / (1 << (IN_W - LUT_AW));
    case (mode)
      0: begin r = i; g = i; b = i; end
      3: begin r = 255 - i; g = 255 - i; b = 255 - i; end
      1: begin
        if (i < 85)       begin r = 3 * i; g = 0;            b = 0; end
        else if (i < 170) begin r = 255;   g = 3 * (i - 85); b = 0; end
        else              begin r = 255;   g = 255;          b = 3 * (i - 170); end
      end
      default: return pal_m[la];
    endcase
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: check outputs against queued expectations, then record accepts.
  always @(negedge clk) begin
    if (lut_we) pal_m[lut_addr] = lut_wdata;
    if (!rst) begin
      q_rgb.delete(); q_sof.delete(); q_cyc.delete();
      m_mode = 0; m_floor = 0; m_gain = 1 << GAIN_FRAC;
    end else begin
      if (bus.out_valid) begin
        check_val("out_has_expect", 32'(q_rgb.size() != 0), 32'd1);
        if (q_rgb.size() != 0) begin
          check_val("rgb", 32'(bus.rgb), 32'(q_rgb[0]));
          if (bus.out_ready) begin
            check_val("out_sof", 32'(bus.out_sof), 32'(q_sof[0]));
            if (chk_lat) check_val("latency", 32'(cyc - q_cyc[0]), 32'd3);
            void'(q_rgb.pop_front()); void'(q_sof.pop_front()); void'(q_cyc.pop_front());
          end
        end
      end
      if (bus.out_ready) check_val("in_ready_free", 32'(bus.in_ready), 32'd1);
      if (bus.in_valid && bus.in_ready) begin
        if (bus.in_sof) begin
          m_mode = int'(cfg_mode); m_floor = int'(cfg_floor); m_gain = int'(cfg_gain);
        end
        q_rgb.push_back(ref_rgb(int'(bus.in_val), m_mode, m_floor, m_gain));
        q_sof.push_back(bus.in_sof);
        q_cyc.push_back(cyc);
      end
    end
  end

  // Present one sample and hold it until accepted (called just after a rising edge).
  task automatic send(input logic [IN_W-1:0] v, input logic sof);
    bit ok;
    ok = 1'b0;
    bus.in_val = v; bus.in_sof = sof; bus.in_valid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check_val("send_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_sof = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && q_rgb.size() != 0; t++) @(posedge clk);
    check_val("drain", 32'(q_rgb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic set_cfg(input logic [1:0] md, input logic [IN_W-1:0] fl, input logic [7:0] gn);
    cfg_mode = md; cfg_floor = fl; cfg_gain = gn;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_val = '0; bus.in_sof = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    set_cfg(2'd0, 12'h000, 8'd16);
    lut_we = 1'b0; lut_addr = '0; lut_wdata = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_rgb", 32'(bus.rgb), 32'd0);
    check_val("rst_out_sof", 32'(bus.out_sof), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("rel_in_ready", 32'(bus.in_ready), 32'd1);

    // fill the palette while idle
    for (int a = 0; a < (1 << LUT_AW); a++) begin
      lut_we = 1'b1; lut_addr = LUT_AW'(a); lut_wdata = 24'($urandom);
      @(posedge clk); #1;
    end
    lut_we = 1'b0;
    @(posedge clk); #1;

    chk_lat = 1'b1;
    // gray, unity gain
    set_cfg(2'd0, 12'h000, 8'd16);
    send(12'h000, 1'b1); send(12'h800, 1'b0); send(12'hFFF, 1'b0);
    drain();
    // heat boundaries
    set_cfg(2'd1, 12'h000, 8'd16);
    send(12'h540, 1'b1); send(12'h550, 1'b0); send(12'hFF0, 1'b0);
    drain();
    // floor, gain x2, saturation
    set_cfg(2'd0, 12'h100, 8'd32);
    send(12'h080, 1'b1); send(12'h900, 1'b0); send(12'h300, 1'b0);
    drain();
    // gain zero
    set_cfg(2'd0, 12'h000, 8'd0);
    send(12'hABC, 1'b1);
    drain();

    // LUT mode and read-first collision
    lut_we = 1'b1; lut_addr = 8'h12; lut_wdata = 24'h123456;
    @(posedge clk); #1;
    lut_we = 1'b0;
    set_cfg(2'd2, 12'h000, 8'd16);
    send(12'h120, 1'b1);
    drain();
    bus.in_val = 12'h120; bus.in_sof = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    lut_we = 1'b1; lut_addr = 8'h12; lut_wdata = 24'hABCDEF;
    @(posedge clk); #1;
    lut_we = 1'b0; bus.in_valid = 1'b0;
    drain();

    // mid-frame config change only lands on the next SOF
    set_cfg(2'd0, 12'h000, 8'd16);
    send(12'h800, 1'b1);
    set_cfg(2'd3, 12'h000, 8'd16);
    send(12'h800, 1'b0);
    send(12'h800, 1'b1);
    drain();

    // backpressure with a continuous stream
    chk_lat = 1'b0;
    set_cfg(2'd0, 12'h000, 8'd16);
    fork
      begin
        for (int k = 0; k < 8; k++) send(IN_W'(k * 12'h111 + 12'h010), 1'(k == 0));
      end
      begin
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_val("stall_in_ready", 32'(bus.in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();

    // reset with samples in flight
    set_cfg(2'd1, 12'h000, 8'd16);
    send(12'h400, 1'b1); send(12'h500, 1'b0); send(12'h600, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_val("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk_lat = 1'b1;
    send(12'h800, 1'b0);
    drain();

    // random traffic with stalls, config churn, no palette writes
    chk_lat = 1'b0;
    for (int n = 0; n < 400; n++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_val    = IN_W'($urandom);
      bus.in_sof    = ($urandom_range(0, 7) == 0);
      cfg_mode      = 2'($urandom);
      cfg_floor     = IN_W'($urandom_range(0, 1023));
      cfg_gain      = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 48));
      bus.out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    drain();

    // random traffic with live palette writes, no stalls
    chk_lat = 1'b1;
    for (int n = 0; n < 300; n++) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_val   = IN_W'($urandom);
      bus.in_sof   = ($urandom_range(0, 7) == 0);
      cfg_mode     = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd2;
      cfg_floor    = IN_W'($urandom_range(0, 255));
      cfg_gain     = 8'($urandom_range(8, 24));
      lut_we       = $urandom_range(0, 1) == 1;
      lut_addr     = LUT_AW'($urandom);
      lut_wdata    = 24'($urandom);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0; lut_we = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
